// File: rtl/binary_to_gray_counter.sv
// binary_to_gray_counter
// Up/down binary counter with a registered Gray-code view of the same count.
// bin and gray come from one next-state value, so they always change on the same edge.
// wrap pulses for one cycle after a count step rolls over in either direction.
// Define GRAY_CHECK_EN to add the sticky err flag. err is set when a count step moves
// gray by anything other than exactly one bit.
module binary_to_gray_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
`ifdef GRAY_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam logic [WIDTH-1:0] Zero    = '0;
    localparam logic [WIDTH-1:0] AllOnes = '1;
    localparam logic [WIDTH-1:0] One     = {{(WIDTH-1){1'b0}}, 1'b1};

    // Operation selected on this edge. Load wins over count, and count wins over hold.
    typedef enum logic [1:0] {
        OpHold,
        OpLoad,
        OpUp,
        OpDown
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    // Pick the operation for this edge.
    always_comb begin
        op = OpHold;
        if (load) begin
            op = OpLoad;
        end else if (en) begin
            op = up ? OpUp : OpDown;
        end
    end

    // Next binary value and roll-over detection. A load never reports a wrap.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        unique case (op)
            OpLoad: begin
                bin_d = load_val;
            end
            OpUp: begin
                bin_d  = bin_q + One;
                wrap_d = (bin_q == AllOnes);
            end
            OpDown: begin
                bin_d  = bin_q - One;
                wrap_d = (bin_q == Zero);
            end
            default: begin
                bin_d = bin_q;
            end
        endcase
    end

    // Gray code of the next value. It is registered alongside bin, so no extra latency.
    always_comb begin
        gray_d = bin_d ^ (bin_d >> 1);
    end

    // Count, code and wrap registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= Zero;
            gray_q <= Zero;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;
    assign wrap = wrap_q;

`ifdef GRAY_CHECK_EN
    logic [WIDTH-1:0] gray_diff;
    logic             one_bit_step;
    logic             err_q, err_d;

    // A count step must flip exactly one gray bit. A load may jump anywhere, so it
    // is not checked.
    always_comb begin
        gray_diff    = gray_q ^ gray_d;
        one_bit_step = (gray_diff != Zero) && ((gray_diff & (gray_diff - One)) == Zero);
        err_d        = err_q;
        if (((op == OpUp) || (op == OpDown)) && !one_bit_step) begin
            err_d = 1'b1;
        end
    end

    // Sticky error flag. Only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_binary_to_gray_counter.sv
// Self-checking bench for binary_to_gray_counter (WIDTH=4).
// The reference model counts with integer arithmetic modulo 2^W.
`timescale 1ns/1ps
module tb_binary_to_gray_counter;

    localparam int W   = 4;
    localparam int Mod = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;
`ifdef GRAY_CHECK_EN
    logic         err;
`endif

    int checks = 0;
    int errors = 0;
    int m_bin  = 0;
    bit m_wrap = 1'b0;

    always #5 clk = ~clk;

    binary_to_gray_counter #(
        .WIDTH(W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .up      (up),
        .load    (load),
        .load_val(load_val),
        .bin     (bin),
        .gray    (gray),
        .wrap    (wrap)
`ifdef GRAY_CHECK_EN
        ,
        .err     (err)
`endif
    );

    function automatic logic [W-1:0] to_gray(input int b);
        logic [W-1:0] v;
        v = b[W-1:0];
        return v ^ (v >> 1);
    endfunction

    // Advance the model for the inputs that are present at the coming edge.
    task automatic model_edge();
        if (!rst_n) begin
            m_bin  = 0;
            m_wrap = 1'b0;
        end else if (load) begin
            m_bin  = int'(load_val);
            m_wrap = 1'b0;
        end else if (en) begin
            if (up) begin
                m_wrap = (m_bin == Mod - 1);
                m_bin  = (m_bin + 1) % Mod;
            end else begin
                m_wrap = (m_bin == 0);
                m_bin  = (m_bin + Mod - 1) % Mod;
            end
        end else begin
            m_wrap = 1'b0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        #2;
        checks++;
        if ({bin, gray, wrap} !== {W'(0), W'(0), 1'b0}) begin
            errors++;
            $display("FAIL reset_async: bin=%b gray=%b wrap=%b, required 0 0 0", bin, gray, wrap);
        end
        // Inputs are ignored while reset is held.
        for (int i = 0; i < 3; i++) begin
            en = 1'b1; up = i[0]; load = 1'b1; load_val = W'($urandom);
            tick();
            checks++;
            if ({bin, gray, wrap} !== {W'(0), W'(0), 1'b0}) begin
                errors++;
                $display("FAIL reset_hold_inputs: bin=%b gray=%b wrap=%b, required 0 0 0",
                         bin, gray, wrap);
            end
        end
        load = 1'b0; en = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_up_count();
        logic [3:0] seq [16];
        seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
        do_reset();
        en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++;
            if ((gray !== seq[k % 16]) || (wrap !== (k == 16)) || (bin !== W'(k % 16))) begin
                errors++;
                $display("FAIL up_count edge %0d: bin=%b gray=%b wrap=%b, required %b %b %b",
                         k, bin, gray, wrap, W'(k % 16), seq[k % 16], (k == 16));
            end
        end
        tick();
        checks++;
        if ((bin !== 4'b0001) || (wrap !== 1'b0)) begin
            errors++;
            $display("FAIL up_after_wrap: bin=%b wrap=%b, required 0001 0", bin, wrap);
        end
        en = 1'b0;
    endtask

    task automatic test_down_count();
        do_reset();
        en = 1'b1; up = 1'b0;
        tick();
        checks++;
        if ({bin, gray, wrap} !== {4'b1111, 4'b1000, 1'b1}) begin
            errors++;
            $display("FAIL down_first: bin=%b gray=%b wrap=%b, required 1111 1000 1",
                     bin, gray, wrap);
        end
        tick();
        checks++;
        if ({bin, gray, wrap} !== {4'b1110, 4'b1001, 1'b0}) begin
            errors++;
            $display("FAIL down_second: bin=%b gray=%b wrap=%b, required 1110 1001 0",
                     bin, gray, wrap);
        end
        en = 1'b0;
    endtask

    task automatic test_load_priority();
        do_reset();
        load = 1'b1; load_val = 4'b1011; en = 1'b1; up = 1'b1;
        tick();
        checks++;
        if ({bin, gray, wrap} !== {4'b1011, 4'b1110, 1'b0}) begin
            errors++;
            $display("FAIL load_value: bin=%b gray=%b wrap=%b, required 1011 1110 0",
                     bin, gray, wrap);
        end
        load = 1'b0;
        tick();
        checks++;
        if ({bin, gray, wrap} !== {4'b1100, 4'b1010, 1'b0}) begin
            errors++;
            $display("FAIL load_then_count: bin=%b gray=%b wrap=%b, required 1100 1010 0",
                     bin, gray, wrap);
        end
        // A load from all-ones to zero is not a roll-over.
        load = 1'b1; load_val = 4'b1111;
        tick();
        load_val = 4'b0000; en = 1'b1; up = 1'b1;
        tick();
        checks++;
        if ({bin, gray, wrap} !== {4'b0000, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL load_no_wrap: bin=%b gray=%b wrap=%b, required 0000 0000 0",
                     bin, gray, wrap);
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_hold();
        load = 1'b1; load_val = 4'b0101;
        tick();
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            up = i[0];
            tick();
            checks++;
            if ({bin, gray, wrap} !== {4'b0101, 4'b0111, 1'b0}) begin
                errors++;
                $display("FAIL hold edge %0d: bin=%b gray=%b wrap=%b, required 0101 0111 0",
                         i, bin, gray, wrap);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        load = 1'b1; load_val = 4'b1110;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        checks++;
        if (bin !== 4'b1111) begin
            errors++;
            $display("FAIL async_setup: bin=%b, required 1111", bin);
        end
        #2;
        rst_n = 1'b0;
        m_bin = 0; m_wrap = 1'b0;
        #1;
        checks++;
        if ({bin, gray, wrap} !== {4'b0000, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL async_midcycle: bin=%b gray=%b wrap=%b, required 0000 0000 0",
                     bin, gray, wrap);
        end
        tick();
        checks++;
        if (wrap !== 1'b0) begin
            errors++;
            $display("FAIL async_no_wrap: wrap=%b, required 0", wrap);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({bin, wrap} !== {4'b0001, 1'b0}) begin
            errors++;
            $display("FAIL async_first_up: bin=%b wrap=%b, required 0001 0", bin, wrap);
        end
        en = 1'b0;
    endtask

    task automatic test_direction_flip();
        load = 1'b1; load_val = 4'b0110;
        tick();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            up = (i % 3) != 0;
            tick();
            checks++;
            if ({bin, gray, wrap} !== {m_bin[W-1:0], to_gray(m_bin), m_wrap}) begin
                errors++;
                $display("FAIL dir_flip edge %0d: bin=%b gray=%b wrap=%b, required %b %b %b",
                         i, bin, gray, wrap, m_bin[W-1:0], to_gray(m_bin), m_wrap);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] prev_gray;
        bit           counted;
        for (int i = 0; i < 300; i++) begin
            load     = ($urandom_range(0, 7) == 0);
            en       = ($urandom_range(0, 3) != 0);
            up       = $urandom_range(0, 1) != 0;
            load_val = W'($urandom);
            counted  = !load && en;
            prev_gray = gray;
            tick();
            checks++;
            if ({bin, gray, wrap} !== {m_bin[W-1:0], to_gray(m_bin), m_wrap}) begin
                errors++;
                $display("FAIL random edge %0d: bin=%b gray=%b wrap=%b, required %b %b %b",
                         i, bin, gray, wrap, m_bin[W-1:0], to_gray(m_bin), m_wrap);
            end
            if (counted) begin
                checks++;
                if ($countones(gray ^ prev_gray) != 1) begin
                    errors++;
                    $display("FAIL gray_one_bit edge %0d: %b -> %b, required one bit change",
                             i, prev_gray, gray);
                end
            end
        end
        load = 1'b0; en = 1'b0;
    endtask

`ifdef GRAY_CHECK_EN
    task automatic test_gray_check();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            load     = (i == 13) || (i == 27);
            load_val = W'($urandom);
            en       = 1'b1;
            up       = $urandom_range(0, 1) != 0;
            tick();
            checks++;
            if ((err !== 1'b0) || (bin !== m_bin[W-1:0])) begin
                errors++;
                $display("FAIL check_clean edge %0d: err=%b bin=%b, required 0 %b",
                         i, err, bin, m_bin[W-1:0]);
            end
        end
        load = 1'b1; load_val = 4'b0100;
        tick();
        // Flip the two top gray bits; the next up step only touches bit 0.
        dut.gray_q <= 4'b1010;
        #1;
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL check_trip: err=%b, required 1", err);
        end
        for (int i = 0; i < 5; i++) begin
            load = (i == 2); load_val = W'($urandom); up = i[0];
            tick();
            checks++;
            if (err !== 1'b1) begin
                errors++;
                $display("FAIL check_sticky edge %0d: err=%b, required 1", i, err);
            end
        end
        load = 1'b0; en = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL check_reset_clear: err=%b, required 0", err);
        end
        tick();
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_up_count();
        test_down_count();
        test_load_priority();
        test_hold();
        test_async_reset();
        test_direction_flip();
        test_random();
`ifdef GRAY_CHECK_EN
        test_gray_check();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
